// File: rtl/pam4_symbol_detector.sv
// PAM-4 symbol slicer with preamble hunt and a first-word-fall-through payload FIFO.
// One decision per SPS samples; after lock, FRAME_LEN symbols are buffered for a ready/valid consumer.
module pam4_symbol_detector #(
  parameter int          SPS        = 64,
  parameter int          THRESH     = 64,
  parameter logic [7:0]  PREAMBLE   = 8'b11_00_11_00,
  parameter int          FRAME_LEN  = 32,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [7:0] sample_in,
  output logic [1:0]        sym_out,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic              locked,
  output logic              overflow
);

  localparam int PHW = $clog2(SPS);
  localparam int PCW = $clog2(FRAME_LEN + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [PHW-1:0]  PH_LAST = PHW'(SPS - 1);
  localparam logic [PCW-1:0]  PC_LAST = PCW'(FRAME_LEN - 1);
  localparam logic [AW:0]     FULL    = (AW + 1)'(FIFO_DEPTH);
  localparam logic signed [8:0] TH_POS = 9'(THRESH);
  localparam logic signed [8:0] TH_NEG = 9'(-THRESH);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t          state;
  logic [PHW-1:0]  phase;
  logic [7:0]      hist;
  logic [PCW-1:0]  pcnt;
  logic [1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  logic signed [8:0] s9;
  logic [1:0]        sym;
  logic [7:0]        hist_next;
  logic              decision;
  logic              push;
  logic              pop;
  logic              full;
  logic              write;

  always_comb begin
    s9 = {sample_in[7], sample_in};
    if (s9 >= TH_POS)      sym = 2'b11;
    else if (s9 >= 9'sd0)  sym = 2'b10;
    else if (s9 >= TH_NEG) sym = 2'b01;
    else                   sym = 2'b00;
  end

  assign hist_next = {hist[5:0], sym};
  assign decision  = (phase == PH_LAST);
  assign push      = decision && (state == LOCKED);
  assign pop       = sym_valid && sym_ready;
  assign full      = (count == FULL);
  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign write     = push && (!full || pop);

  assign sym_valid = (count != '0);
  assign sym_out   = sym_valid ? mem[rd_ptr] : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      phase    <= '0;
      hist     <= '0;
      pcnt     <= '0;
      locked   <= 1'b0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      phase <= phase + PHW'(1);

      if (decision) begin
        case (state)
          SEARCH: begin
            hist <= hist_next;
            if (hist_next == PREAMBLE) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (pcnt == PC_LAST) begin
              state  <= SEARCH;
              locked <= 1'b0;
              pcnt   <= '0;
              hist   <= '0;
            end else begin
              pcnt <= pcnt + PCW'(1);
            end
          end
          default: state <= SEARCH;
        endcase
      end

      if (push && full && !pop) overflow <= 1'b1;
      if (write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);

      case ({write, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && write) mem[wr_ptr] <= sym;
  end

endmodule

// File: tb/tb_pam4_symbol_detector.sv
// Bench for pam4_symbol_detector: three instances (FRAME_LEN 4/8/12) share stimulus and
// are checked against directed expectations and a behavioural per-cycle model.
module tb_pam4_symbol_detector;

  localparam int SPS   = 4;
  localparam int DEPTH = 8;

  logic              clk;
  logic              rst;
  logic              ready;
  logic signed [7:0] sample_in;

  logic [1:0] so [3];
  logic       sv [3];
  logic       lk [3];
  logic       ov [3];

  int checks = 0;
  int errors = 0;

  int m_phase [3];
  int m_hist  [3];
  int m_pc    [3];
  int m_cnt   [3];
  int m_fifo  [3][DEPTH];
  bit m_lk    [3];
  bit m_ov    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pam4_symbol_detector #(
      .SPS(SPS), .THRESH(64), .PREAMBLE(8'hCC), .FRAME_LEN(4 * (g + 1)), .FIFO_DEPTH(DEPTH)
    ) dut (
      .clk(clk), .rst(rst), .sample_in(sample_in),
      .sym_out(so[g]), .sym_valid(sv[g]), .sym_ready(ready),
      .locked(lk[g]), .overflow(ov[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int slice(input int s);
    if (s >= 64)       return 3;
    else if (s >= 0)   return 2;
    else if (s >= -64) return 1;
    else               return 0;
  endfunction

  // Behavioural frame/FIFO model, advanced once per rising edge with the inputs of that cycle.
  function automatic void model_step(input int k);
    bit pop, full, dec;
    int sym;
    if (rst) begin
      m_phase[k] = 0; m_hist[k] = 0; m_pc[k] = 0; m_cnt[k] = 0;
      m_lk[k] = 1'b0; m_ov[k] = 1'b0;
      return;
    end
    pop  = (m_cnt[k] > 0) && ready;
    full = (m_cnt[k] == DEPTH);
    dec  = (m_phase[k] == SPS - 1);
    m_phase[k] = (m_phase[k] + 1) % SPS;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) m_fifo[k][i] = m_fifo[k][i+1];
      m_cnt[k]--;
    end
    if (dec) begin
      sym = slice(int'(sample_in));
      if (!m_lk[k]) begin
        m_hist[k] = (m_hist[k] * 4 + sym) % 256;
        if (m_hist[k] == 204) m_lk[k] = 1'b1;
      end else begin
        if (!full || pop) begin
          m_fifo[k][m_cnt[k]] = sym;
          m_cnt[k]++;
        end else begin
          m_ov[k] = 1'b1;
        end
        m_pc[k]++;
        if (m_pc[k] == 4 * (k + 1)) begin
          m_lk[k] = 1'b0; m_pc[k] = 0; m_hist[k] = 0;
        end
      end
    end
  endfunction

  function automatic logic [4:0] obs(input int k);
    return {sv[k], so[k], lk[k], ov[k]};
  endfunction

  function automatic logic [4:0] expv(input int k);
    logic [4:0] r;
    r[4]   = (m_cnt[k] > 0);
    r[3:2] = (m_cnt[k] > 0) ? 2'(m_fifo[k][0]) : 2'b00;
    r[1]   = m_lk[k];
    r[0]   = m_ov[k];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
  endtask

  task automatic hold(input int v, input int n);
    sample_in = 8'(v);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1; sample_in = 8'sd100;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs(k) !== 5'b0) begin
        errors++; $display("FAIL reset_outputs dut%0d: got %b want 00000", k, obs(k));
      end
    end
    rst = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (lk[k] !== 1'b0 || obs(k) !== expv(k)) begin
        errors++; $display("FAIL reset_release dut%0d: got %b want %b", k, obs(k), expv(k));
      end
    end
  endtask

  task automatic test_preamble();
    int nm [4] = '{100, -100, 100, -30};
    int pa [4] = '{100, -100, 100, -100};
    for (int i = 0; i < 4; i++) begin
      hold(nm[i], 4);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (lk[k] !== 1'b0) begin
          errors++; $display("FAIL near_miss dut%0d sym%0d: locked=%b want 0", k, i, lk[k]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      hold(pa[i], 3);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (lk[k] !== 1'b0 || sv[k] !== 1'b0) begin
          errors++; $display("FAIL preamble_pre dut%0d sym%0d: locked=%b valid=%b want 0 0", k, i, lk[k], sv[k]);
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (lk[k] !== (i == 3) || sv[k] !== 1'b0) begin
          errors++; $display("FAIL preamble_dec dut%0d sym%0d: locked=%b valid=%b want %b 0", k, i, lk[k], sv[k], (i == 3));
        end
      end
    end
  endtask

  task automatic test_slicer_boundaries();
    int         v [8] = '{127, 64, 63, 0, -1, -64, -65, -128};
    logic [1:0] e [8] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 8; i++) begin
      hold(v[i], 3);
      checks++;
      if (sv[1] !== 1'b0) begin
        errors++; $display("FAIL slicer_idle sym%0d: valid=%b want 0", i, sv[1]);
      end
      tick();
      checks++;
      if (sv[1] !== 1'b1 || so[1] !== e[i]) begin
        errors++; $display("FAIL slicer_sym sym%0d: valid=%b sym=%b want 1 %b", i, sv[1], so[1], e[i]);
      end
      checks++;
      if (lk[1] !== (i < 7)) begin
        errors++; $display("FAIL frame8_locked sym%0d: got %b want %b", i, lk[1], (i < 7));
      end
      checks++;
      if (lk[0] !== (i < 3) || sv[0] !== (i < 4)) begin
        errors++; $display("FAIL frame4_end sym%0d: locked=%b valid=%b want %b %b", i, lk[0], sv[0], (i < 3), (i < 4));
      end
    end
  endtask

  task automatic test_frame_end_relock();
    hold(100, 4); hold(-100, 4); hold(100, 4); hold(-100, 4);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (lk[k] !== 1'b1) begin
        errors++; $display("FAIL relock dut%0d: locked=%b want 1", k, lk[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] e [12];
    rst = 1'b1; tick(); rst = 1'b0;
    hold(100, 4); hold(-100, 4); hold(100, 4); hold(-100, 4);
    checks++;
    if (lk[2] !== 1'b1) begin
      errors++; $display("FAIL bp_lock: locked=%b want 1", lk[2]);
    end
    ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sample_in = 8'($urandom_range(0, 255));
      e[i] = 2'(slice(int'(sample_in)));
      repeat (4) tick();
      checks++;
      if (ov[2] !== (i >= 8) || sv[2] !== 1'b1 || lk[2] !== (i < 11)) begin
        errors++; $display("FAIL bp_fill sym%0d: ovf=%b valid=%b locked=%b want %b 1 %b", i, ov[2], sv[2], lk[2], (i >= 8), (i < 11));
      end
    end
    sample_in = 8'sd0;
    ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (sv[2] !== 1'b1 || so[2] !== e[j]) begin
        errors++; $display("FAIL bp_drain item%0d: valid=%b sym=%b want 1 %b", j, sv[2], so[2], e[j]);
      end
      tick();
    end
    checks++;
    if (sv[2] !== 1'b0 || ov[2] !== 1'b1) begin
      errors++; $display("FAIL bp_empty: valid=%b ovf=%b want 0 1", sv[2], ov[2]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs(k) !== expv(k)) begin
        errors++; $display("FAIL bp_model dut%0d: got %b want %b", k, obs(k), expv(k));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    checks++;
    if (ov[2] !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b want 1", ov[2]);
    end
    ready = 1'b0;
    hold(100, 4); hold(-100, 4); hold(100, 4); hold(-100, 4);
    hold(100, 8);
    checks++;
    if (lk[2] !== 1'b1 || sv[2] !== 1'b1) begin
      errors++; $display("FAIL mid_frame_pre: locked=%b valid=%b want 1 1", lk[2], sv[2]);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sv[k] !== 1'b0 || lk[k] !== 1'b0 || ov[k] !== 1'b0) begin
        errors++; $display("FAIL mid_frame_rst dut%0d: valid=%b locked=%b ovf=%b want 0 0 0", k, sv[k], lk[k], ov[k]);
      end
    end
    // A stale 11001100 history would lock after just two of these decisions.
    hold(100, 4); hold(-100, 4);
    checks++;
    if (lk[2] !== 1'b0) begin
      errors++; $display("FAIL hist_cleared: locked=%b want 0", lk[2]);
    end
    hold(100, 4); hold(-100, 4);
    checks++;
    if (lk[2] !== 1'b1) begin
      errors++; $display("FAIL relock_after_rst: locked=%b want 1", lk[2]);
    end
  endtask

  task automatic test_random();
    int lvl;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ((c % 1000) < 300) ready = ($urandom_range(0, 9) == 0);
      else                  ready = ($urandom_range(0, 3) != 0);
      if (((c / 4) % 16) < 8) begin
        lvl = (((c / 4) % 2) == 0) ? 100 : -100;
        sample_in = 8'(lvl + int'($urandom_range(0, 40)) - 20);
      end else begin
        sample_in = 8'($urandom_range(0, 255));
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++; $display("FAIL random cyc%0d dut%0d: got %b want %b", c, k, obs(k), expv(k));
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; sample_in = 8'sd0;
    test_reset();
    test_preamble();
    test_slicer_boundaries();
    test_frame_end_relock();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
